// File: rtl/branch_resolution_unit_pkg.sv
// Shared types for the branch resolution stage: ALU micro-op encoding,
// resolution FSM states and fall-through increments.
package branch_resolution_unit_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT,
        ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_uop_t;

    typedef enum logic {
        RUN,
        WAIT_FLUSH
    } bru_state_t;

    localparam int unsigned FALL_THROUGH_COMPRESSED = 2;
    localparam int unsigned FALL_THROUGH_STANDARD   = 4;

    // Unconditional jumps are always taken regardless of the ALU condition bit.
    function automatic logic is_jump(input alu_uop_t op);
        return (op == ALU_JAL) || (op == ALU_JALR);
    endfunction

endpackage

// File: rtl/branch_resolution_unit_target_adder.sv
// Branch target computation: base + offset, with bit 0 forced low for JALR.
module branch_target_adder
    import branch_resolution_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic            is_jalr,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] sum;

    assign sum    = base + offset;
    assign target = {sum[XLEN-1:1], sum[0] & ~is_jalr};

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves branches after the ALU, raises a one-cycle redirect on mispredict
// and drops wrong-path results until the front end acknowledges the flush.
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            flush_ack_i,
    input  logic            data_valid_i,
    input  logic            is_branch_i,
    input  alu_uop_t        operation_i,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] instr_addr_i,
    input  logic [XLEN-1:0] base_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            is_jalr_i,
    input  logic            is_cjump_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] correct_pc_o,
    output logic            bpu_update_o,
    output logic            bpu_taken_o,
    output logic [XLEN-1:0] bpu_addr_o,
    output logic [XLEN-1:0] bpu_target_o,
    output logic [31:0]     branch_count_o,
    output logic [31:0]     mispredict_count_o
);

    bru_state_t      state_reg, state_next;
    logic            accept;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] correct_pc;

    branch_target_adder #(.XLEN(XLEN)) u_target_adder (
        .base    (base_i),
        .offset  (offset_i),
        .is_jalr (is_jalr_i),
        .target  (target)
    );

    assign accept       = data_valid_i & ~stall_i & (state_reg == RUN);
    assign taken        = is_jump(operation_i) | result_i[0];
    assign fall_through = instr_addr_i + (is_cjump_i ? XLEN'(FALL_THROUGH_COMPRESSED)
                                                     : XLEN'(FALL_THROUGH_STANDARD));
    assign mispredict   = is_branch_i & ((taken != pred_taken_i) |
                                         (taken & (target != pred_target_i)));
    assign correct_pc   = taken ? target : fall_through;

    // The flush exit ignores stall so a redirect is never lost behind a stall.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:        if (accept && mispredict) state_next = WAIT_FLUSH;
            WAIT_FLUSH: if (flush_ack_i)          state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg          <= RUN;
            result_o           <= '0;
            result_valid_o     <= 1'b0;
            mispredict_o       <= 1'b0;
            correct_pc_o       <= '0;
            bpu_update_o       <= 1'b0;
            bpu_taken_o        <= 1'b0;
            bpu_addr_o         <= '0;
            bpu_target_o       <= '0;
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            state_reg <= state_next;
            if (!stall_i) begin
                result_valid_o <= accept;
                bpu_update_o   <= accept & is_branch_i;
                mispredict_o   <= accept & mispredict;
                if (accept) begin
                    result_o <= result_i;
                end
                if (accept && is_branch_i) begin
                    correct_pc_o   <= correct_pc;
                    bpu_taken_o    <= taken;
                    bpu_addr_o     <= instr_addr_i;
                    bpu_target_o   <= target;
                    branch_count_o <= branch_count_o + 32'd1;
                    if (mispredict) begin
                        mispredict_count_o <= mispredict_count_o + 32'd1;
                    end
                end
            end
        end
    end

endmodule
